// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage core: load-use bubbles,
// taken-branch flushes, fetch wait states, start-up freeze and perf counters.
module hazard_ctrl #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int INIT_CYCLES    = 2,
    parameter int TIMEOUT        = 15,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [6:0]                IF_ID_inst_opcode,
    input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs2,
    input  logic [6:0]                ID_EX_inst_opcode,
    input  logic [REG_ADDR_WIDTH-1:0] ID_EX_rd,
    input  logic                      branch_taken,
    input  logic                      imem_busy,
    output logic                      pc_write_en,
    output logic                      IF_ID_write_en,
    output logic                      IF_ID_flush,
    output logic                      ctr_sel,
    output logic                      fetch_err,
    output logic [CNT_WIDTH-1:0]      stall_cnt,
    output logic [CNT_WIDTH-1:0]      flush_cnt
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int WW = $clog2(TIMEOUT);
    localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYCLES - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_MEM_WAIT,
        ST_ERROR
    } state_t;

    state_t               r_state;
    logic [IW-1:0]        r_init_cnt;
    logic [WW-1:0]        r_wait_cnt;
    logic [CNT_WIDTH-1:0] r_stall_cnt;
    logic [CNT_WIDTH-1:0] r_flush_cnt;

    logic w_rs1_used;
    logic w_rs2_used;
    logic w_load_use;
    logic w_stall_inc;
    logic w_flush_inc;

    assign w_rs1_used = !(IF_ID_inst_opcode == OP_LUI || IF_ID_inst_opcode == OP_AUIPC ||
                          IF_ID_inst_opcode == OP_JAL);
    assign w_rs2_used = (IF_ID_inst_opcode == OP_RTYPE || IF_ID_inst_opcode == OP_STORE ||
                         IF_ID_inst_opcode == OP_BRANCH);
    assign w_load_use = (ID_EX_inst_opcode == OP_LOAD) && (ID_EX_rd != '0) &&
                        ((w_rs1_used && IF_ID_rs1 == ID_EX_rd) ||
                         (w_rs2_used && IF_ID_rs2 == ID_EX_rd));

    // Default is the FREEZE set; each state only overrides what differs.
    always_comb begin
        pc_write_en    = 1'b0;
        IF_ID_write_en = 1'b0;
        IF_ID_flush    = 1'b0;
        ctr_sel        = 1'b0;
        w_stall_inc    = 1'b0;
        w_flush_inc    = 1'b0;
        case (r_state)
            ST_INIT: IF_ID_flush = 1'b1;
            ST_RUN: begin
                if (branch_taken) begin
                    pc_write_en    = 1'b1;
                    IF_ID_write_en = 1'b1;
                    IF_ID_flush    = 1'b1;
                    w_flush_inc    = 1'b1;
                end else if (imem_busy || w_load_use) begin
                    w_stall_inc = 1'b1;
                end else begin
                    pc_write_en    = 1'b1;
                    IF_ID_write_en = 1'b1;
                    ctr_sel        = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (branch_taken) begin
                    pc_write_en    = 1'b1;
                    IF_ID_write_en = 1'b1;
                    IF_ID_flush    = 1'b1;
                    w_flush_inc    = 1'b1;
                end else begin
                    w_stall_inc = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_INIT;
            r_init_cnt  <= '0;
            r_wait_cnt  <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_inc && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_flush_inc && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + 1'b1;
            case (r_state)
                ST_INIT: begin
                    if (r_init_cnt == INIT_LAST) r_state <= ST_RUN;
                    else                         r_init_cnt <= r_init_cnt + 1'b1;
                end
                ST_RUN: begin
                    // The busy cycle seen here counts as the first wait cycle.
                    if (imem_busy) begin
                        r_state    <= ST_MEM_WAIT;
                        r_wait_cnt <= WW'(1);
                    end
                end
                ST_MEM_WAIT: begin
                    if (!branch_taken) begin
                        if (!imem_busy)                r_state <= ST_RUN;
                        else if (r_wait_cnt == WAIT_LAST) r_state <= ST_ERROR;
                        else                           r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_ERROR;
            endcase
        end
    end

    assign fetch_err = (r_state == ST_ERROR);
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios then random traffic,
// checked cycle by cycle against a rule-level reference model.
module tb_hazard_ctrl;
    localparam int RW = 5;
    localparam int INIT_CYCLES = 2;
    localparam int TIMEOUT = 15;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_ALUI = 7'b0010011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [6:0]    if_op = OP_ALUI;
    logic [RW-1:0] if_rs1 = '0;
    logic [RW-1:0] if_rs2 = '0;
    logic [6:0]    ex_op = OP_ALUI;
    logic [RW-1:0] ex_rd = '0;
    logic          bt = 1'b0;
    logic          busy = 1'b0;
    logic          pc_we, ifid_we, ifid_fl, ctr, ferr;
    logic [CW-1:0] s_cnt, f_cnt;

    hazard_ctrl #(.REG_ADDR_WIDTH(RW), .INIT_CYCLES(INIT_CYCLES), .TIMEOUT(TIMEOUT),
                  .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset),
        .IF_ID_inst_opcode(if_op), .IF_ID_rs1(if_rs1), .IF_ID_rs2(if_rs2),
        .ID_EX_inst_opcode(ex_op), .ID_EX_rd(ex_rd),
        .branch_taken(bt), .imem_busy(busy),
        .pc_write_en(pc_we), .IF_ID_write_en(ifid_we), .IF_ID_flush(ifid_fl),
        .ctr_sel(ctr), .fetch_err(ferr), .stall_cnt(s_cnt), .flush_cnt(f_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic pc, we, fl, ctr, err;
        logic [CW-1:0] sc, fc;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: plain integers, mode 0=init 1=run 2=wait 3=error
    int m_mode = 0, m_init_left = INIT_CYCLES, m_busy_seen = 0, m_stall = 0, m_flush = 0;
    logic [6:0] opcodes [8] = '{7'b0000011, 7'b0110011, 7'b0100011, 7'b1100011,
                                7'b0110111, 7'b0010111, 7'b1101111, 7'b0010011};

    function automatic bit ref_load_use();
        bit u1, u2;
        u1 = !(if_op inside {7'b0110111, 7'b0010111, 7'b1101111});
        u2 = (if_op inside {7'b0110011, 7'b0100011, 7'b1100011});
        return (ex_op == OP_LOAD) && (ex_rd != 0) &&
               ((u1 && if_rs1 == ex_rd) || (u2 && if_rs2 == ex_rd));
    endfunction

    function automatic int sat(int v);
        return (v < CMAX) ? v + 1 : CMAX;
    endfunction

    task automatic model_step();
        exp_t e;
        bit freeze, flush;
        freeze = 1'b0; flush = 1'b0;
        e = '0;
        if (reset) begin
            m_mode = 0; m_init_left = INIT_CYCLES; m_stall = 0; m_flush = 0;
            e.fl = 1'b1;
            q.push_back(e);
            return;
        end
        e.sc = CW'(m_stall);
        e.fc = CW'(m_flush);
        e.err = (m_mode == 3);
        case (m_mode)
            0: begin
                e.fl = 1'b1;
                m_init_left--;
                if (m_init_left == 0) m_mode = 1;
            end
            1: begin
                if (bt) begin
                    flush = 1'b1; m_flush = sat(m_flush);
                    if (busy) begin m_mode = 2; m_busy_seen = 1; end
                end else if (busy) begin
                    m_stall = sat(m_stall); m_mode = 2; m_busy_seen = 1;
                end else if (ref_load_use()) begin
                    m_stall = sat(m_stall);
                end else begin
                    e.pc = 1'b1; e.we = 1'b1; e.ctr = 1'b1;
                end
            end
            2: begin
                if (bt) begin
                    flush = 1'b1; m_flush = sat(m_flush);
                end else if (!busy) begin
                    m_stall = sat(m_stall); m_mode = 1;
                end else begin
                    m_stall = sat(m_stall);
                    m_busy_seen++;
                    if (m_busy_seen == TIMEOUT) m_mode = 3;
                end
            end
            default: ;
        endcase
        if (flush) begin e.pc = 1'b1; e.we = 1'b1; e.fl = 1'b1; end
        q.push_back(e);
    endtask

    task automatic cyc(input bit rst, input logic [6:0] iop, input int r1, input int r2,
                       input logic [6:0] eop, input int rd, input bit b, input bit bz);
        @(posedge clk);
        #1;
        reset = rst; if_op = iop; if_rs1 = RW'(r1); if_rs2 = RW'(r2);
        ex_op = eop; ex_rd = RW'(rd); bt = b; busy = bz;
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, OP_ALUI, 0, 0, OP_ALUI, 0, 0, 0);
    endtask

    task automatic do_reset();
        cyc(1, OP_ALUI, 0, 0, OP_ALUI, 0, 0, 0);
        cyc(1, OP_ALUI, 0, 0, OP_ALUI, 0, 0, 0);
    endtask

    initial begin : monitor
        exp_t e, a;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                a = '{pc_we, ifid_we, ifid_fl, ctr, ferr, s_cnt, f_cnt};
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL outputs @%0t: got pc=%b we=%b fl=%b ctr=%b err=%b sc=%0d fc=%0d, want pc=%b we=%b fl=%b ctr=%b err=%b sc=%0d fc=%0d",
                             $time, a.pc, a.we, a.fl, a.ctr, a.err, a.sc, a.fc,
                             e.pc, e.we, e.fl, e.ctr, e.err, e.sc, e.fc);
                end
            end
        end
    end

    initial begin : stimulus
        int burst, rst_left;
        do_reset();
        idle(4);
        cyc(0, OP_R, 5, 1, OP_LOAD, 5, 0, 0);
        cyc(0, OP_R, 5, 1, OP_ALUI, 0, 0, 0);
        idle(1);
        cyc(0, OP_R, 0, 1, OP_LOAD, 0, 0, 0);
        cyc(0, OP_LUI, 5, 5, OP_LOAD, 5, 0, 0);
        cyc(0, OP_ALUI, 0, 0, OP_ALUI, 0, 1, 0);
        idle(1);
        cyc(0, OP_R, 5, 1, OP_LOAD, 5, 1, 0);
        idle(1);
        for (int i = 0; i < 3; i++) cyc(0, OP_ALUI, 0, 0, OP_ALUI, 0, 0, 1);
        idle(2);
        cyc(0, OP_ALUI, 0, 0, OP_ALUI, 0, 0, 1);
        cyc(0, OP_ALUI, 0, 0, OP_ALUI, 0, 1, 1);
        cyc(0, OP_ALUI, 0, 0, OP_ALUI, 0, 0, 1);
        idle(2);
        cyc(0, OP_R, 5, 1, OP_LOAD, 5, 1, 1);
        idle(2);
        do_reset();
        idle(3);
        for (int i = 0; i < 20; i++) cyc(0, OP_ALUI, 0, 0, OP_ALUI, 0, 0, 1);
        idle(3);
        do_reset();
        idle(3);
        for (int i = 0; i < 20; i++) cyc(0, OP_R, 3, 3, OP_LOAD, 3, 0, 0);
        idle(2);
        do_reset();

        burst = 0; rst_left = 0;
        for (int i = 0; i < 3000; i++) begin
            bit r, b, bz;
            if (rst_left > 0) rst_left--;
            else if ($urandom_range(0, 99) == 0) rst_left = $urandom_range(1, 2);
            r = (rst_left > 0);
            if (burst > 0) burst--;
            else if ($urandom_range(0, 9) == 0) burst = $urandom_range(1, 18);
            bz = (burst > 0);
            b = ($urandom_range(0, 7) == 0);
            cyc(r, opcodes[$urandom_range(0, 7)], $urandom_range(0, 3), $urandom_range(0, 3),
                ($urandom_range(0, 1) == 1) ? OP_LOAD : opcodes[$urandom_range(0, 7)],
                $urandom_range(0, 3), b, bz);
        end

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected entries left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
